// File: rtl/proctypes.sv
// Shared primitive types for the triangle processing pipeline.
package proctypes;

  // One screen-space triangle as handed from the fetch stage to the rasterizers.
  typedef struct packed {
    logic [15:0] id;
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
  } Triangle;

endpackage

// File: rtl/triangle_dispatcher.sv
// Triangle dispatcher: buffers fetched triangles in a small FIFO and hands
// them round-robin to a set of rasterizer units, tracking frame completion.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | out of reset, no frame active; nothing is popped
// RUN    | frame active, upstream still fetching; dispatch as units allow
// DRAIN  | upstream finished; wait out in-flight fetches, FIFO and units
// DONE   | frame fully dispatched and every unit idle; frame_done held high
module triangle_dispatcher
  import proctypes::*;
#(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SKID       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 upstream_busy,
  input  logic                 in_valid,
  input  Triangle              in_triangle,
  output logic                 in_ready,
  input  logic [NUM_UNITS-1:0] unit_ready,
  input  logic [NUM_UNITS-1:0] unit_busy,
  output logic [NUM_UNITS-1:0] unit_valid,
  output Triangle              unit_triangle,
  output logic                 frame_done,
  output logic [15:0]          dispatched_count,
  output logic                 overflow
);

  localparam int unsigned    AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned    GW         = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [AW:0]    DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0]  LAST_UNIT  = GW'(NUM_UNITS - 1);
  // Covers the two-cycle fetch latency plus the push landing in the FIFO.
  localparam logic [1:0]     DRAIN_LOAD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           drain_cnt_q, drain_cnt_d;
  logic                 frame_done_q, frame_done_d;

  Triangle              mem_q [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]          count_q, count_d;

  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [NUM_UNITS-1:0] unit_valid_q, unit_valid_d;
  Triangle              unit_tri_q, unit_tri_d;
  logic [15:0]          disp_cnt_q, disp_cnt_d;
  logic                 overflow_q, overflow_d;

  logic                 fifo_empty, fifo_full;
  logic                 pop_en, push_en, drop_en;
  logic                 frame_active;

  logic                 grant_found;
  logic [GW-1:0]        grant_idx;
  logic [NUM_UNITS-1:0] grant_oh;
  int unsigned          cand;
  logic [GW-1:0]        cand_idx;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == DEPTH_C);
  assign frame_active = (state_q == S_RUN) || (state_q == S_DRAIN);

  // A frame_start cycle neither pops nor pushes: the FIFO is being flushed.
  assign pop_en  = frame_active && !frame_start && !fifo_empty && (|unit_ready);
  assign push_en = in_valid && !frame_start && (!fifo_full || pop_en);
  assign drop_en = in_valid && !frame_start && fifo_full && !pop_en;

  // Headroom for fetches already in flight when in_ready is sampled upstream.
  assign in_ready = ((32'(count_q) + SKID) < FIFO_DEPTH);

  assign unit_valid       = unit_valid_q;
  assign unit_triangle    = unit_tri_q;
  assign frame_done       = frame_done_q;
  assign dispatched_count = disp_cnt_q;
  assign overflow         = overflow_q;

  // Round-robin search for the first ready unit after the last one granted.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= NUM_UNITS; k++) begin
      cand     = (32'(last_grant_q) + k) % NUM_UNITS;
      cand_idx = GW'(cand);
      if (!grant_found && unit_ready[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  // FIFO bookkeeping, dispatch register, counters and sticky overflow.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    unit_valid_d = '0;
    unit_tri_d   = unit_tri_q;
    disp_cnt_d   = disp_cnt_q;
    overflow_d   = overflow_q;
    if (frame_start) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      last_grant_d = LAST_UNIT;
      disp_cnt_d   = '0;
      overflow_d   = 1'b0;
    end else begin
      if (pop_en) begin
        rd_ptr_d     = rd_ptr_q + 1'b1;
        unit_valid_d = grant_oh;
        unit_tri_d   = mem_q[rd_ptr_q];
        last_grant_d = grant_idx;
        if (disp_cnt_q != 16'hFFFF) begin
          disp_cnt_d = disp_cnt_q + 16'd1;
        end
      end
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (push_en && !pop_en) begin
        count_d = count_q + 1'b1;
      end else if (pop_en && !push_en) begin
        count_d = count_q - 1'b1;
      end
      if (drop_en) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Frame sequencing: next state, drain timer and the sticky done flag.
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    frame_done_d = frame_done_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (!upstream_busy) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (upstream_busy) begin
          state_d = S_RUN;
        end else if (drain_cnt_q != 2'd0) begin
          drain_cnt_d = drain_cnt_q - 2'd1;
        end else if (fifo_empty && (unit_valid_q == '0) && (unit_busy == '0)) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (frame_start) begin
      state_d      = S_RUN;
      drain_cnt_d  = 2'd0;
      frame_done_d = 1'b0;
    end
  end

  // Triangle storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= in_triangle;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      drain_cnt_q  <= 2'd0;
      frame_done_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= LAST_UNIT;
      unit_valid_q <= '0;
      unit_tri_q   <= '0;
      disp_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      frame_done_q <= frame_done_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      unit_valid_q <= unit_valid_d;
      unit_tri_q   <= unit_tri_d;
      disp_cnt_q   <= disp_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Bench for triangle_dispatcher: directed frame scenarios plus a randomized
// stretch, all compared against a queue-based reference model.
module tb_triangle_dispatcher;
  import proctypes::*;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int SK    = 2;
  localparam int GW    = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          upstream_busy;
  logic          in_valid;
  Triangle       in_triangle;
  logic          in_ready;
  logic [N-1:0]  unit_ready;
  logic [N-1:0]  unit_busy;
  logic [N-1:0]  unit_valid;
  Triangle       unit_triangle;
  logic          frame_done;
  logic [15:0]   dispatched_count;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  Triangle       mq[$];
  bit            m_active;
  int            m_last;
  logic [N-1:0]  m_uv;
  Triangle       m_ut;
  int            m_cnt;
  logic          m_ovf;
  int            tri_seq;

  triangle_dispatcher #(.NUM_UNITS(N), .FIFO_DEPTH(DEPTH), .SKID(SK)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_start      (frame_start),
    .upstream_busy    (upstream_busy),
    .in_valid         (in_valid),
    .in_triangle      (in_triangle),
    .in_ready         (in_ready),
    .unit_ready       (unit_ready),
    .unit_busy        (unit_busy),
    .unit_valid       (unit_valid),
    .unit_triangle    (unit_triangle),
    .frame_done       (frame_done),
    .dispatched_count (dispatched_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_tri(output Triangle t);
    t.id = 16'(tri_seq);
    t.v0 = $urandom;
    t.v1 = $urandom;
    t.v2 = $urandom;
    tri_seq++;
  endtask

  task automatic m_reset();
    mq.delete();
    m_active = 1'b0;
    m_last   = N - 1;
    m_uv     = '0;
    m_ut     = '0;
    m_cnt    = 0;
    m_ovf    = 1'b0;
  endtask

  // Advance the model by one clock using the inputs now applied, clock the
  // DUT, then compare every observable output just after the edge.
  task automatic cycle();
    bit            pop;
    bit            full;
    int            g;
    int            u;
    logic [GW-1:0] ui;
    full = (mq.size() == DEPTH);
    pop  = m_active && (mq.size() > 0) && (unit_ready != '0) && !frame_start;
    if (frame_start) begin
      mq.delete();
      m_cnt    = 0;
      m_ovf    = 1'b0;
      m_last   = N - 1;
      m_uv     = '0;
      m_active = 1'b1;
    end else begin
      m_uv = '0;
      if (pop) begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          u  = (m_last + k) % N;
          ui = GW'(u);
          if (g < 0 && unit_ready[ui]) g = u;
        end
        ui       = GW'(g);
        m_uv[ui] = 1'b1;
        m_ut     = mq.pop_front();
        m_last   = g;
        if (m_cnt < 65535) m_cnt++;
      end
      if (in_valid) begin
        if (!full || pop) mq.push_back(in_triangle);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("unit_valid",       128'(unit_valid),       128'(m_uv));
    chk("unit_triangle",    128'(unit_triangle),    128'(m_ut));
    chk("dispatched_count", 128'(dispatched_count), 128'(m_cnt));
    chk("overflow",         128'(overflow),         128'(m_ovf));
    chk("in_ready",         128'(in_ready),         128'((mq.size() + SK) < DEPTH));
  endtask

  initial begin
    logic [N-1:0] exp_seq [5];
    logic [N-1:0] rnd;
    bit           seen;

    exp_seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
    rst_n = 1'b0; frame_start = 1'b0; upstream_busy = 1'b1; in_valid = 1'b0;
    in_triangle = '0; unit_ready = '0; unit_busy = '0; tri_seq = 1;
    m_reset();

    // Reset values, observed while reset is held
    #1;
    chk("rst_unit_valid",  128'(unit_valid),       128'(0));
    chk("rst_unit_tri",    128'(unit_triangle),    128'(0));
    chk("rst_in_ready",    128'(in_ready),         128'(1));
    chk("rst_frame_done",  128'(frame_done),       128'(0));
    chk("rst_count",       128'(dispatched_count), 128'(0));
    chk("rst_overflow",    128'(overflow),         128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // IDLE: a buffered triangle must not be dispatched before frame_start
    unit_ready = '1; in_valid = 1'b1; next_tri(in_triangle);
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    chk("idle_no_dispatch", 128'(unit_valid), 128'(0));

    // Three back-to-back triangles, all units ready
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      next_tri(in_triangle);
      cycle();
      chk("seq_grant", 128'(unit_valid), 128'(exp_seq[i]));
    end
    chk("seq_count", 128'(dispatched_count), 128'(3));

    // Fill with no ready units: in_ready falls at 6, 9th push overflows
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    unit_ready = '0;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; next_tri(in_triangle);
      cycle();
      chk("fill_in_ready", 128'(in_ready), 128'(i < 6));
      chk("fill_overflow", 128'(overflow), 128'(i >= 9));
    end
    in_valid = 1'b0;

    // frame_start with a full FIFO and a coincident in_valid
    frame_start = 1'b1; in_valid = 1'b1; unit_ready = '1; next_tri(in_triangle);
    cycle();
    frame_start = 1'b0; in_valid = 1'b0;
    chk("flush_valid",    128'(unit_valid),       128'(0));
    chk("flush_count",    128'(dispatched_count), 128'(0));
    chk("flush_overflow", 128'(overflow),         128'(0));
    chk("flush_in_ready", 128'(in_ready),         128'(1));
    cycle();
    chk("flush_empty", 128'(unit_valid), 128'(0));

    // frame_start with 5 triangles buffered
    unit_ready = '0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; next_tri(in_triangle); cycle();
    end
    in_valid = 1'b0; frame_start = 1'b1; unit_ready = '1;
    cycle();
    frame_start = 1'b0;
    chk("flush5_valid", 128'(unit_valid), 128'(0));
    chk("flush5_count", 128'(dispatched_count), 128'(0));
    cycle();
    chk("flush5_empty", 128'(unit_valid), 128'(0));

    // Round-robin: only unit 2 ready, then units 0 and 2 ready
    frame_start = 1'b1; unit_ready = '0; cycle(); frame_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; next_tri(in_triangle); cycle();
    end
    in_valid = 1'b0; cycle();
    unit_ready = 4'b0100; cycle();
    chk("rr_only2", 128'(unit_valid), 128'(4'b0100));
    unit_ready = 4'b0101; cycle();
    chk("rr_wrap", 128'(unit_valid), 128'(4'b0001));
    unit_ready = '0;

    // Randomized traffic with occasional mid-stream frame_start
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      frame_start = ($urandom_range(0, 59) == 0);
      in_valid    = ($urandom_range(0, 2) != 0);
      next_tri(in_triangle);
      rnd = N'($urandom);
      if ((i / 100) % 2 == 0) rnd = rnd & N'($urandom) & N'($urandom);
      unit_ready = rnd;
      unit_busy  = N'($urandom);
      cycle();
    end
    frame_start = 1'b0; in_valid = 1'b0; unit_busy = '0;

    // Drain: two late triangles after upstream_busy falls, done waits for busy
    frame_start = 1'b1; unit_ready = '1; cycle(); frame_start = 1'b0;
    unit_busy = 4'b0011; upstream_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; next_tri(in_triangle); cycle();
    end
    upstream_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; next_tri(in_triangle); cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("drain_busy_not_done", 128'(frame_done), 128'(0));
    end
    chk("drain_count", 128'(dispatched_count), 128'(5));
    unit_busy = '0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = frame_done;
    end
    chk("drain_done_timeout", 128'(seen), 128'(1));
    cycle();
    chk("done_sticky", 128'(frame_done), 128'(1));
    upstream_busy = 1'b1; frame_start = 1'b1; cycle(); frame_start = 1'b0;
    chk("restart_done_clear", 128'(frame_done), 128'(0));

    // Asynchronous reset in the middle of dispatch
    unit_ready = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; next_tri(in_triangle); cycle();
    end
    in_valid = 1'b0; unit_ready = '1;
    cycle();
    chk("pre_rst_valid", 128'(unit_valid), 128'(4'b0001));
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_valid",      128'(unit_valid),       128'(0));
    chk("arst_frame_done", 128'(frame_done),       128'(0));
    chk("arst_in_ready",   128'(in_ready),         128'(1));
    chk("arst_count",      128'(dispatched_count), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("post_rst_dropped", 128'(dispatched_count), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
